// File: rtl/sram_bus_pkg.sv
// Shared types and helpers for the async SRAM bus controller.
package sram_bus_pkg;

    // Controller sequencing states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD_STROBE = 3'd1,
        ST_WR_SETUP  = 3'd2,
        ST_WR_PULSE  = 3'd3,
        ST_WR_HOLD   = 3'd4
    } sram_bus_state_t;

    // Number of byte-wide chips / write-enable lanes in a data word
    function automatic int lanes(input int data_width, input int lane_width);
        return data_width / lane_width;
    endfunction

endpackage

// File: rtl/sram_bus_ctrl_if.sv
// Request stream plus SRAM chip-side signals of the controller.
// slave  = controller view, master = CPU memory stage + chip bank view.
interface sram_bus_ctrl_if
    import sram_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int LANE_WIDTH = 8
);
    localparam int LANES = lanes(DATA_WIDTH, LANE_WIDTH);

    logic                  REQ_VALID;
    logic                  REQ_READY;
    logic                  REQ_WE;
    logic [ADDR_WIDTH-1:0] REQ_ADDR;
    logic [LANES-1:0]      REQ_BE;
    logic [DATA_WIDTH-1:0] REQ_WDATA;
    logic                  RD_VALID;
    logic [DATA_WIDTH-1:0] RD_DATA;
    logic [ADDR_WIDTH-1:0] SRAM_ADDR;
    logic                  SRAM_N_OE;
    logic [LANES-1:0]      SRAM_N_WE;
    logic                  SRAM_DRIVE;
    logic [DATA_WIDTH-1:0] SRAM_OUT_DATA;
    logic [DATA_WIDTH-1:0] SRAM_IN_DATA;

    modport slave (
        input  REQ_VALID, REQ_WE, REQ_ADDR, REQ_BE, REQ_WDATA, SRAM_IN_DATA,
        output REQ_READY, RD_VALID, RD_DATA,
               SRAM_ADDR, SRAM_N_OE, SRAM_N_WE, SRAM_DRIVE, SRAM_OUT_DATA
    );

    modport master (
        output REQ_VALID, REQ_WE, REQ_ADDR, REQ_BE, REQ_WDATA, SRAM_IN_DATA,
        input  REQ_READY, RD_VALID, RD_DATA,
               SRAM_ADDR, SRAM_N_OE, SRAM_N_WE, SRAM_DRIVE, SRAM_OUT_DATA
    );

endinterface

// File: rtl/sram_bus_ctrl.sv
// Sequences single-word requests into N_OE / per-lane N_WE strobes for a bank of
// asynchronous byte-wide SRAMs, with programmable strobe length and write
// setup/hold cycles. All chip-side outputs come straight from flops.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | ready for a request, all strobes released
// ST_RD_STROBE | N_OE low for WAIT_STATES+1 cycles, data sampled on last edge
// ST_WR_SETUP  | address/data driven, N_WE still high
// ST_WR_PULSE  | N_WE[i] = ~BE[i] for WAIT_STATES+1 cycles
// ST_WR_HOLD   | N_WE released, address/data/drive held one more cycle
module sram_bus_ctrl
    import sram_bus_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int LANE_WIDTH  = 8,
    parameter int WAIT_STATES = 1
)(
    input  logic            CLK,
    input  logic            RST,
    sram_bus_ctrl_if.slave  bus
);

    localparam int LANES  = lanes(DATA_WIDTH, LANE_WIDTH);
    localparam int WAIT_W = $clog2(WAIT_STATES + 1) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_STATES);

    sram_bus_state_t       r_state;
    sram_bus_state_t       w_state_nxt;
    logic [WAIT_W-1:0]     r_wait;
    logic [WAIT_W-1:0]     w_wait_nxt;

    logic [LANES-1:0]      r_be;
    logic [ADDR_WIDTH-1:0] r_sram_addr;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_n_oe;
    logic [LANES-1:0]      r_n_we;
    logic                  r_drive;
    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] r_rd_data;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_rd_done;
    logic                  w_n_oe_nxt;
    logic [LANES-1:0]      w_n_we_nxt;
    logic                  w_drive_nxt;

    assign w_ready   = (r_state == ST_IDLE) && !RST;
    assign w_accept  = bus.REQ_VALID && w_ready;
    assign w_rd_done = (r_state == ST_RD_STROBE) && (r_wait == '0);

    // State and wait counter register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
        end
    end

    // Next-state and wait-counter decode; the counter down-counts each strobe phase
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (bus.REQ_WE) begin
                        w_state_nxt = ST_WR_SETUP;
                    end else begin
                        w_state_nxt = ST_RD_STROBE;
                        w_wait_nxt  = WAIT_LOAD;
                    end
                end
            end
            ST_RD_STROBE: begin
                if (r_wait == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_wait_nxt = r_wait - WAIT_W'(1);
                end
            end
            ST_WR_SETUP: begin
                w_state_nxt = ST_WR_PULSE;
                w_wait_nxt  = WAIT_LOAD;
            end
            ST_WR_PULSE: begin
                if (r_wait == '0) begin
                    w_state_nxt = ST_WR_HOLD;
                end else begin
                    w_wait_nxt = r_wait - WAIT_W'(1);
                end
            end
            ST_WR_HOLD: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_wait_nxt  = '0;
            end
        endcase
    end

    // Strobe values decoded from the upcoming state so the flops below carry them glitch-free
    always_comb begin
        w_n_oe_nxt  = (w_state_nxt != ST_RD_STROBE);
        w_drive_nxt = (w_state_nxt == ST_WR_SETUP) ||
                      (w_state_nxt == ST_WR_PULSE) ||
                      (w_state_nxt == ST_WR_HOLD);
        w_n_we_nxt  = '1;
        if (w_state_nxt == ST_WR_PULSE) begin
            w_n_we_nxt = ~r_be;
        end
    end

    // Chip-side outputs, captured request fields and read return path
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_be        <= '0;
            r_sram_addr <= '0;
            r_out_data  <= '0;
            r_n_oe      <= 1'b1;
            r_n_we      <= '1;
            r_drive     <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
        end else begin
            r_n_oe     <= w_n_oe_nxt;
            r_n_we     <= w_n_we_nxt;
            r_drive    <= w_drive_nxt;
            r_rd_valid <= w_rd_done;
            if (w_rd_done) begin
                r_rd_data <= bus.SRAM_IN_DATA;
            end
            if (w_accept) begin
                r_sram_addr <= bus.REQ_ADDR;
                if (bus.REQ_WE) begin
                    r_be       <= bus.REQ_BE;
                    r_out_data <= bus.REQ_WDATA;
                end
            end
        end
    end

    assign bus.REQ_READY     = w_ready;
    assign bus.RD_VALID      = r_rd_valid;
    assign bus.RD_DATA       = r_rd_data;
    assign bus.SRAM_ADDR     = r_sram_addr;
    assign bus.SRAM_N_OE     = r_n_oe;
    assign bus.SRAM_N_WE     = r_n_we;
    assign bus.SRAM_DRIVE    = r_drive;
    assign bus.SRAM_OUT_DATA = r_out_data;

`ifdef FORMAL
`ifndef CONTRACT
`define CONTRACT assume
`endif
    // The chips never see output enable together with a write strobe or our drive
    a_no_contention: assert property (@(posedge CLK) disable iff (RST)
        !(!r_n_oe && (r_drive || (r_n_we != '1))));

    // Drive only while a write sequence owns the bus
    a_drive_in_wr: assert property (@(posedge CLK) disable iff (RST)
        r_drive |-> (r_state inside {ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD}));

    // Address never moves while any write strobe is low
    a_addr_stable: assert property (@(posedge CLK) disable iff (RST)
        (r_n_we != '1) |=> $stable(r_sram_addr));

    // Requests are well-formed and accepted requests leave IDLE
    `CONTRACT property (@(posedge CLK) disable iff (RST) !$isunknown(bus.REQ_VALID));
    a_accept_leaves_idle: assert property (@(posedge CLK) disable iff (RST)
        w_accept |=> (r_state != ST_IDLE));
    a_ready_only_idle: assert property (@(posedge CLK) disable iff (RST)
        bus.REQ_READY |-> (r_state == ST_IDLE));
`endif

endmodule
